// File: rtl/ahb_mtx_dec_n.sv
// ahb_mtx_dec_n: AHB bus-matrix input-port decoder.
//
// Decodes the input-stage address (HADDR[31:10]) into a one-hot select for
// NUM_PORTS output stages. An address that matches no region goes to an
// integrated default slave, which answers with a two-cycle ERROR response.
// The output stage that owns the current data phase drives the response
// (ready, resp, rdata, ruser) back to the input stage through a mux. Active
// transfers to unmapped addresses are counted, and the last such address is
// kept for debug.
//
// Ports:
//   HCLK, HRESETn          clock, async active-low reset
//   HREADYS                input-stage HREADY (transfer accepted)
//   sel_dec, trans_dec     input-stage HSEL / HTRANS
//   decode_addr_dec        HADDR[31:10]
//   active_dec_i           per-output-stage active flags
//   readyout_dec_i, resp_dec_i, rdata_dec_i, ruser_dec_i
//                          per-output-stage data-phase responses, packed
//   err_clr                synchronous clear of err_count
//   sel_dec_o              one-hot HSEL to the output stages
//   active_dec             active flag of the addressed target
//   HREADYOUTS, HRESPS, HRDATAS, HRUSERS
//                          muxed data-phase response
//   err_count, err_addr    decode-error debug counter and last bad address
//
// Default-slave states:
//   state   | meaning
//   DS_IDLE | no error pending; zero-wait OKAY
//   DS_ERR1 | first ERROR cycle, wait state (ready=0)
//   DS_ERR2 | second ERROR cycle, completes transfer (ready=1)

module ahb_mtx_dec_n #(
  parameter int                      NUM_PORTS    = 4,
  parameter int                      DATA_W       = 32,
  parameter int                      USER_W       = 32,
  parameter logic [22*NUM_PORTS-1:0] REGION_BASE  = {NUM_PORTS{22'h0}},
  parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h3F}},
  parameter int                      CNT_W        = 8
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HREADYS,
  input  logic                        sel_dec,
  input  logic [21:0]                 decode_addr_dec,
  input  logic [1:0]                  trans_dec,
  input  logic [NUM_PORTS-1:0]        active_dec_i,
  input  logic [NUM_PORTS-1:0]        readyout_dec_i,
  input  logic [2*NUM_PORTS-1:0]      resp_dec_i,
  input  logic [DATA_W*NUM_PORTS-1:0] rdata_dec_i,
  input  logic [USER_W*NUM_PORTS-1:0] ruser_dec_i,
  input  logic                        err_clr,
  output logic [NUM_PORTS-1:0]        sel_dec_o,
  output logic                        active_dec,
  output logic                        HREADYOUTS,
  output logic [1:0]                  HRESPS,
  output logic [DATA_W-1:0]           HRDATAS,
  output logic [USER_W-1:0]           HRUSERS,
  output logic [CNT_W-1:0]            err_count,
  output logic [21:0]                 err_addr
);

  // Port encodings 0..NUM_PORTS-1 are output stages; NUM_PORTS is the
  // default slave.
  localparam int             PW  = $clog2(NUM_PORTS + 1);
  localparam logic [PW-1:0]  DFT = PW'(NUM_PORTS);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  ds_state_e         state_q, state_d;
  logic [PW-1:0]     data_port_q, data_port_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [21:0]       err_addr_q, err_addr_d;

  logic [PW-1:0]     addr_port;
  logic              hit_any;
  logic              sel_dft;
  logic              dft_acc;
  logic              dft_ready;
  logic [1:0]        dft_resp;

  // Address decode. Scanning from the top down lets the lowest-index hit
  // overwrite higher ones, which gives lowest-index priority on overlap.
  always_comb begin
    addr_port = DFT;
    hit_any   = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if ((decode_addr_dec >= REGION_BASE[22*k +: 22]) &&
          (decode_addr_dec <= REGION_LIMIT[22*k +: 22])) begin
        addr_port = PW'(k);
        hit_any   = 1'b1;
      end
    end
    // An IDLE to an unmapped address keeps pointing at the current data
    // port so the default slave is not selected for nothing.
    if (!hit_any && (trans_dec == 2'b00)) begin
      addr_port = data_port_q;
    end
  end

  always_comb begin
    sel_dec_o  = '0;
    active_dec = 1'b1;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (addr_port == PW'(k)) begin
        sel_dec_o[k] = sel_dec;
        active_dec   = active_dec_i[k];
      end
    end
  end

  assign sel_dft = sel_dec & (addr_port == DFT);
  assign dft_acc = sel_dft & HREADYS & trans_dec[1];

  assign data_port_d = HREADYS ? addr_port : data_port_q;

  // Default-slave FSM.
  always_comb begin
    state_d   = state_q;
    dft_ready = 1'b1;
    dft_resp  = 2'b00;
    case (state_q)
      DS_IDLE: begin
        if (dft_acc) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        dft_ready = 1'b0;
        dft_resp  = 2'b01;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        dft_resp = 2'b01;
        state_d  = dft_acc ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

  // Data-phase response mux.
  always_comb begin
    HREADYOUTS = dft_ready;
    HRESPS     = dft_resp;
    HRDATAS    = '0;
    HRUSERS    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (data_port_q == PW'(k)) begin
        HREADYOUTS = readyout_dec_i[k];
        HRESPS     = resp_dec_i[2*k +: 2];
        HRDATAS    = rdata_dec_i[DATA_W*k +: DATA_W];
        HRUSERS    = ruser_dec_i[USER_W*k +: USER_W];
      end
    end
  end

  // Decode-error counter; a clear coinciding with an error leaves that one
  // error counted.
  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (err_clr) begin
      err_count_d = dft_acc ? CNT_W'(1) : '0;
    end else if (dft_acc && (err_count_q != {CNT_W{1'b1}})) begin
      err_count_d = err_count_q + CNT_W'(1);
    end
    if (dft_acc) begin
      err_addr_d = decode_addr_dec;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= DS_IDLE;
      data_port_q <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_port_q <= data_port_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: doc/ahb_mtx_dec_n.md
Name: ahb_mtx_dec_n

Overview:
Parametrised AHB bus-matrix input-port decoder. Maps each input-stage address to one of NUM_PORTS output stages, or to an integrated default slave when the address is unmapped. Muxes the data-phase response back to the input stage and counts decode errors for debug.
It sits between one matrix input stage and NUM_PORTS output stages.

Parameters:
NUM_PORTS, 4, number of output ports (1..8)
DATA_W, 32, HRDATA width
USER_W, 32, HRUSER width
REGION_BASE, {NUM_PORTS{22'h0}}, packed 22-bit lower bounds, port k at [22k+21:22k], in HADDR[31:10] units
REGION_LIMIT, {NUM_PORTS{22'h3F}}, packed 22-bit inclusive upper bounds
CNT_W, 8, width of decode-error counter

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  async active-low reset
HREADYS  in  1  input-stage HREADY (transfer done)
sel_dec  in  1  input-stage HSEL
decode_addr_dec  in  22  HADDR[31:10]
trans_dec  in  2  HTRANS
active_dec_i  in  NUM_PORTS  output-stage active flags
readyout_dec_i  in  NUM_PORTS  output-stage HREADYOUT
resp_dec_i  in  2*NUM_PORTS  output-stage HRESP, packed
rdata_dec_i  in  DATA_W*NUM_PORTS  output-stage HRDATA, packed
ruser_dec_i  in  USER_W*NUM_PORTS  output-stage HRUSER, packed
err_clr  in  1  synchronous clear for err_count
sel_dec_o  out  NUM_PORTS  one-hot HSEL to output stages
active_dec  out  1  active flag of addressed target
HREADYOUTS  out  1  muxed HREADYOUT
HRESPS  out  2  muxed HRESP
HRDATAS  out  DATA_W  muxed read data
HRUSERS  out  USER_W  muxed read user data
err_count  out  CNT_W  saturating count of unmapped active transfers
err_addr  out  22  decode_addr_dec of most recent unmapped active transfer

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK, rising edge.
- Address decode (combinational):
  - hit[k] = (decode_addr_dec >= BASE[k]) & (decode_addr_dec <= LIMIT[k]).
  - Lowest-index hit wins on overlap.
  - If no port hits and trans_dec==IDLE, the address port equals the current data port. This avoids spurious default-slave selection on IDLE.
  - Otherwise, no hit selects the default slave (DFT).
- sel_dec_o[k] = sel_dec & (addr_port==k). Default slave is selected by sel_dec & (addr_port==DFT). At most one select is high.
- active_dec = active_dec_i[addr_port] when a port is addressed; 1 when DFT is addressed.
- Data port register:
  - Loads addr_port when HREADYS=1; otherwise holds.
  - Reset value is port 0.
  - Never X; unused encodings are unreachable.
- Data-phase mux:
  - Port k selected: HREADYOUTS, HRESPS, HRDATAS, HRUSERS come from port k.
  - DFT selected: HRDATAS=0, HRUSERS=0; HREADYOUTS and HRESPS come from the default-slave FSM.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: outputs READY=1, RESP=OKAY(00). Goes to ERR1 if sel_dft & HREADYS & trans_dec[1].
  - ERR1: outputs READY=0, RESP=ERROR(01). Always goes to ERR2.
  - ERR2: outputs READY=1, RESP=ERROR(01). Goes to ERR1 if a new DFT active transfer is accepted this cycle; otherwise IDLE.
  - IDLE or BUSY transfers to DFT get a zero-wait OKAY.
  - Reset forces IDLE, including mid-response.
- Error counter:
  - Increment event: sel_dft & HREADYS & trans_dec[1].
  - err_count saturates at all-ones. err_clr=1 clears it to 0.
  - err_clr and an increment in the same cycle gives err_count=1.
  - err_addr loads decode_addr_dec on each increment event.
  - Reset values: err_count=0, err_addr=0.
- Output reset values (data port 0, FSM IDLE):
  - HREADYOUTS = readyout_dec_i[0], HRESPS = resp_dec_i[1:0], HRDATAS = rdata_dec_i[0].
  - sel_dec_o and active_dec follow the combinational decode.
- Latency: address phase is combinational; data-phase select takes effect on the cycle after HREADYS=1; DFT error response is 2 cycles.

Test Plan:
Config: NUM_PORTS=3. P0 0x000000-0x00003F; P1 0x080000-0x08003F; P2 0x100000-0x13FFFF.
- NONSEQ to 0x2000_0004 (decode 0x080000), sel=1, HREADYS=1 -> sel_dec_o=3'b010 that cycle. Next cycle HRDATAS = rdata_dec_i port 1 and HREADYOUTS follows readyout_dec_i[1].
- NONSEQ to 0x3000_0000 -> sel_dec_o=0, active_dec=1. Next cycle HREADYOUTS=0 with HRESPS=01; following cycle HREADYOUTS=1 with HRESPS=01, HRDATAS=0. err_count=1, err_addr=0x0C0000.
- Back-to-back unmapped NONSEQ accepted in ERR2 -> ERR1 re-entered with no OKAY gap; err_count=2.
- IDLE to unmapped address while data port is P2 -> addr_port stays P2, sel_dec_o=3'b100, no DFT response, err_count unchanged.
- Overlap config P0=P1=0x0..0x3F, NONSEQ to 0x0 -> sel_dec_o=3'b001. Port 1 stall (readyout_dec_i[1]=0 for 3 cycles) -> data port held; HREADYOUTS=0 for 3 cycles.
- 255 errors then 1 more -> err_count=255 (saturated). err_clr with a simultaneous error -> 1. HRESPN asserted during ERR1 -> FSM IDLE, HREADYOUTS = readyout_dec_i[0].
